// File: rtl/game_pkg.sv
// game_pkg: game flow state encoding shared with the HUD/VGA muxes, plus a counter sizing helper.
package game_pkg;
  typedef enum logic [2:0] {START, PLAY, PAUSE, RESPAWN, LEVEL_GAP, GAME_OVER, WIN} game_state_t;
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/rising_edge_det.sv
// rising_edge_det: one-cycle pulse on a 0->1 transition of a key level.
module rising_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic pulse
);
  logic prev;
  always_ff @(posedge clk)
    prev <= reset ? 1'b0 : in;
  assign pulse = in & ~prev;
endmodule

// File: rtl/game_flow_controller.sv
// game_flow_controller: top-level game state machine driving display selects and HUD counters.
module game_flow_controller import game_pkg::*; #(
  parameter int NUM_LEVELS = 3,
  parameter int NUM_LIVES = 3,
  parameter int RESPAWN_CYCLES = 50000000,
  parameter int LEVEL_GAP_CYCLES = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic startGame,
  input  logic pauseToggle,
  input  logic timeout,
  input  logic monster_pacmanCollision,
  input  logic levelCleared,
  output logic startDisplay,
  output logic playGame,
  output logic pauseDisplay,
  output logic respawnDisplay,
  output logic levelGapDisplay,
  output logic endDisplay,
  output logic winDisplay,
  output logic respawnPulse,
  output logic levelStartPulse,
  output logic [$clog2(NUM_LEVELS+1)-1:0] level,
  output logic [$clog2(NUM_LIVES+1)-1:0] lives
);
  localparam int LW = $clog2(NUM_LEVELS+1);
  localparam int VW = $clog2(NUM_LIVES+1);
  localparam int CW = cnt_width(RESPAWN_CYCLES, LEVEL_GAP_CYCLES);
  game_state_t state, state_n;
  logic [LW-1:0] level_n;
  logic [VW-1:0] lives_n;
  logic [CW-1:0] cnt, cnt_n;
  logic rp_n, lp_n, start_edge, pause_edge;
  rising_edge_det u_start (.clk(clk), .reset(reset), .in(startGame), .pulse(start_edge));
  rising_edge_det u_pause (.clk(clk), .reset(reset), .in(pauseToggle), .pulse(pause_edge));
  always_ff @(posedge clk)
    if (reset) begin
      state <= START;
      level <= '0;
      lives <= VW'(NUM_LIVES);
      cnt <= '0;
      respawnPulse <= 1'b0;
      levelStartPulse <= 1'b0;
    end else begin
      state <= state_n;
      level <= level_n;
      lives <= lives_n;
      cnt <= cnt_n;
      respawnPulse <= rp_n;
      levelStartPulse <= lp_n;
    end
  // The delay counter defaults to zero so it is cleared on every state entry.
  always_comb begin
    state_n = state;
    level_n = level;
    lives_n = lives;
    cnt_n = '0;
    rp_n = 1'b0;
    lp_n = 1'b0;
    case (state)
      START:
        if (start_edge) begin
          state_n = PLAY;
          level_n = '0;
          lives_n = VW'(NUM_LIVES);
          lp_n = 1'b1;
        end
      PLAY:
        if (levelCleared)
          state_n = (level == LW'(NUM_LEVELS-1)) ? WIN : LEVEL_GAP;
        else if (timeout)
          state_n = GAME_OVER;
        else if (monster_pacmanCollision) begin
          lives_n = lives - VW'(1);
          state_n = (lives == VW'(1)) ? GAME_OVER : RESPAWN;
          rp_n = (lives != VW'(1));
        end else if (pause_edge)
          state_n = PAUSE;
      PAUSE:
        state_n = pause_edge ? PLAY : PAUSE;
      RESPAWN:
        if (cnt == CW'(RESPAWN_CYCLES-1))
          state_n = PLAY;
        else
          cnt_n = cnt + CW'(1);
      LEVEL_GAP:
        if (cnt == CW'(LEVEL_GAP_CYCLES-1)) begin
          state_n = PLAY;
          level_n = level + LW'(1);
          lp_n = 1'b1;
        end else
          cnt_n = cnt + CW'(1);
      GAME_OVER, WIN:
        state_n = start_edge ? START : state;
      default:
        state_n = START;
    endcase
  end
  assign startDisplay = (state == START);
  assign playGame = (state == PLAY);
  assign pauseDisplay = (state == PAUSE);
  assign respawnDisplay = (state == RESPAWN);
  assign levelGapDisplay = (state == LEVEL_GAP);
  assign endDisplay = (state == GAME_OVER);
  assign winDisplay = (state == WIN);
endmodule
